// File: rtl/fir_filter_prog.sv
// Pipelined signed FIR filter with run-time programmable coefficients.
// Stages: delay line (edge A), products (edge B), sum/round/saturate (edge C).

module fir_filter_prog #(
  parameter int N_TAPS     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 0
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           clr,
  input  logic                                           coef_we,
  input  logic [((N_TAPS > 1) ? $clog2(N_TAPS) : 1)-1:0] coef_addr,
  input  logic signed [COEF_WIDTH-1:0]                   coef_data,
  input  logic                                           in_valid,
  input  logic signed [DATA_WIDTH-1:0]                   x_in,
  output logic                                           out_valid,
  output logic signed [OUT_WIDTH-1:0]                    y_out,
  output logic                                           sat_flag
);

  localparam int ProdW = DATA_WIDTH + COEF_WIDTH;
  localparam int AccW  = ProdW + $clog2(N_TAPS);
  localparam int RndW  = AccW + 1;
  localparam int CmpW  = (RndW > OUT_WIDTH) ? RndW : OUT_WIDTH;
  localparam int RndSh = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [RndW-1:0] RndInc = (SHIFT > 0) ? (RndW'(1) << RndSh) : '0;
  localparam logic signed [CmpW-1:0] MaxV =
      {{(CmpW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [CmpW-1:0] MinV =
      {{(CmpW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic signed [COEF_WIDTH-1:0] coef_q [N_TAPS];
  logic signed [COEF_WIDTH-1:0] coef_d [N_TAPS];
  logic signed [DATA_WIDTH-1:0] dly_q  [N_TAPS];
  logic signed [DATA_WIDTH-1:0] dly_d  [N_TAPS];
  logic signed [ProdW-1:0]      prod_q [N_TAPS];
  logic signed [ProdW-1:0]      prod_d [N_TAPS];

  logic                         vld_a_q, vld_a_d;
  logic                         vld_b_q, vld_b_d;
  logic                         out_valid_q, out_valid_d;
  logic                         sat_q, sat_d;
  logic signed [OUT_WIDTH-1:0]  y_q, y_d;

  logic signed [AccW-1:0]       acc;
  logic signed [RndW-1:0]       rnd;
  logic signed [CmpW-1:0]       res;
  logic signed [OUT_WIDTH-1:0]  y_sat;
  logic                         sat_hit;

  // Full-precision sum is wide enough that no tap combination can overflow it.
  always_comb begin
    acc = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      acc = acc + AccW'(prod_q[k]);
    end
    rnd = RndW'(acc) + RndInc;
    res = CmpW'(rnd >>> SHIFT);
    sat_hit = 1'b0;
    y_sat   = res[OUT_WIDTH-1:0];
    if (res > MaxV) begin
      y_sat   = MaxV[OUT_WIDTH-1:0];
      sat_hit = 1'b1;
    end else if (res < MinV) begin
      y_sat   = MinV[OUT_WIDTH-1:0];
      sat_hit = 1'b1;
    end
  end

  always_comb begin
    coef_d      = coef_q;
    dly_d       = dly_q;
    prod_d      = prod_q;
    vld_a_d     = vld_a_q;
    vld_b_d     = vld_b_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    sat_d       = sat_q;

    if (coef_we && (int'(coef_addr) < N_TAPS)) begin
      coef_d[coef_addr] = coef_data;
    end

    if (clr) begin
      // Flush datapath; y_out/sat_flag keep their last values.
      for (int k = 0; k < N_TAPS; k++) begin
        dly_d[k]  = '0;
        prod_d[k] = '0;
      end
      vld_a_d     = 1'b0;
      vld_b_d     = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (in_valid) begin
        dly_d[0] = x_in;
        for (int k = 1; k < N_TAPS; k++) begin
          dly_d[k] = dly_q[k-1];
        end
      end
      vld_a_d = in_valid;
      for (int k = 0; k < N_TAPS; k++) begin
        prod_d[k] = ProdW'(dly_q[k]) * ProdW'(coef_q[k]);
      end
      vld_b_d     = vld_a_q;
      out_valid_d = vld_b_q;
      if (vld_b_q) begin
        y_d   = y_sat;
        sat_d = sat_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        coef_q[k] <= COEF_WIDTH'(1);
        dly_q[k]  <= '0;
        prod_q[k] <= '0;
      end
      vld_a_q     <= 1'b0;
      vld_b_q     <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      coef_q      <= coef_d;
      dly_q       <= dly_d;
      prod_q      <= prod_d;
      vld_a_q     <= vld_a_d;
      vld_b_q     <= vld_b_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign sat_flag  = sat_q;

endmodule
